// File: rtl/dma_multiplane_tlp_addr_gen.sv
// Multi-plane PCIe write-request generator: walks each line of each plane in TLP-sized
// chunks limited by the effective max payload and by 4 KB address boundaries.
module dma_multiplane_tlp_addr_gen #(
  parameter int unsigned NUM_PLANES            = 3,
  parameter int unsigned ADDR_WIDTH            = 64,
  parameter int unsigned LSIZE_WIDTH           = 14,
  parameter int unsigned LINES_WIDTH           = 12,
  parameter int unsigned MAX_PCIE_PAYLOAD_SIZE = 128,
  parameter int unsigned PEND_WIDTH            = 3
) (
  input  logic                             axi_clk,
  input  logic                             axi_reset_n,
  input  logic                             cfg_bus_mast_en,
  input  logic [2:0]                       cfg_setmaxpld,
  input  logic [NUM_PLANES*ADDR_WIDTH-1:0] fstart,
  input  logic [LSIZE_WIDTH-1:0]           line_size,
  input  logic [LSIZE_WIDTH-1:0]           line_pitch,
  input  logic [LINES_WIDTH-1:0]           num_lines,
  input  logic                             frame_start,
  input  logic                             line_ready,
  output logic                             req_valid,
  input  logic                             req_ready,
  output logic [ADDR_WIDTH-1:0]            req_addr,
  output logic [9:0]                       req_len_dw,
  output logic [1:0]                       req_plane,
  output logic                             req_eol,
  output logic                             req_eof,
  output logic                             busy,
  output logic                             frame_done,
  output logic                             pend_ovf
);

  // Chunk/remaining width: must hold both a full line and a 4096 B chunk.
  localparam int unsigned CW = (LSIZE_WIDTH > 13) ? LSIZE_WIDTH : 13;

  typedef enum logic [2:0] {StIdle, StWait, StCalc, StIssue, StNext} state_e;

  state_e                  r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_base [NUM_PLANES];
  logic [ADDR_WIDTH-1:0]   w_base_nxt [NUM_PLANES];
  logic [LSIZE_WIDTH-1:0]  r_size, w_size_nxt, r_pitch, w_pitch_nxt;
  logic [LINES_WIDTH-1:0]  r_num_lines, w_num_lines_nxt, r_line_cnt, w_line_cnt_nxt;
  logic [CW-1:0]           r_eff, w_eff_nxt, r_rem, w_rem_nxt, r_chunk, w_chunk_nxt;
  logic [ADDR_WIDTH-1:0]   r_cur_addr, w_cur_addr_nxt;
  logic [1:0]              r_plane, w_plane_nxt;
  logic [PEND_WIDTH-1:0]   r_pend, w_pend_nxt;
  logic                    r_ovf, w_ovf_nxt, r_held;

  logic [2:0]              w_sel;
  logic [CW-1:0]           w_eff, w_eff_raw, w_bound, w_chunk;
  logic [12:0]             w_bound13;
  logic                    w_last_plane, w_last_line, w_accept, w_do_next, w_start_line, w_inc;
  logic [1:0]              w_next_plane;
  logic [ADDR_WIDTH-1:0]   w_next_base;

  always_comb begin
    w_sel     = (cfg_setmaxpld > 3'd5) ? 3'd5 : cfg_setmaxpld;
    w_eff_raw = CW'(128) << w_sel;
    w_eff     = (w_eff_raw > CW'(MAX_PCIE_PAYLOAD_SIZE)) ? CW'(MAX_PCIE_PAYLOAD_SIZE) : w_eff_raw;
    w_bound13 = 13'h1000 - {1'b0, r_cur_addr[11:0]};
    w_bound   = CW'(w_bound13);
    w_chunk   = r_rem;
    if (r_eff < w_chunk)   w_chunk = r_eff;
    if (w_bound < w_chunk) w_chunk = w_bound;
    w_next_plane = r_plane + 2'd1;
    w_next_base  = r_base[0];
    for (int unsigned p = 0; p < NUM_PLANES; p++) begin
      if (2'(p) == w_next_plane) w_next_base = r_base[p];
    end
  end

  assign w_last_plane = (r_plane == 2'(NUM_PLANES - 1));
  assign w_last_line  = (r_line_cnt == LINES_WIDTH'(r_num_lines - LINES_WIDTH'(1)));
  assign busy         = (r_state != StIdle);
  assign req_valid    = (r_state == StIssue) && (cfg_bus_mast_en || r_held);
  assign w_accept     = req_valid && req_ready;
  assign req_addr     = r_cur_addr;
  assign req_len_dw   = r_chunk[11:2];
  assign req_plane    = r_plane;
  assign req_eol      = (r_state == StIssue) && (r_rem == r_chunk);
  assign req_eof      = req_eol && w_last_plane && w_last_line;
  assign pend_ovf     = r_ovf;

  always_comb begin
    w_state_nxt     = r_state;
    w_base_nxt      = r_base;
    w_size_nxt      = r_size;
    w_pitch_nxt     = r_pitch;
    w_num_lines_nxt = r_num_lines;
    w_line_cnt_nxt  = r_line_cnt;
    w_eff_nxt       = r_eff;
    w_rem_nxt       = r_rem;
    w_chunk_nxt     = r_chunk;
    w_cur_addr_nxt  = r_cur_addr;
    w_plane_nxt     = r_plane;
    w_pend_nxt      = r_pend;
    w_ovf_nxt       = r_ovf;
    frame_done      = 1'b0;
    w_start_line    = 1'b0;
    w_do_next       = 1'b0;
    w_inc           = line_ready && (r_state != StIdle);

    unique case (r_state)
      StIdle: begin
        if (frame_start) begin
          for (int unsigned p = 0; p < NUM_PLANES; p++) begin
            w_base_nxt[p] = fstart[p*ADDR_WIDTH +: ADDR_WIDTH] & ~ADDR_WIDTH'(3);
          end
          w_size_nxt      = {line_size[LSIZE_WIDTH-1:2], 2'b00};
          // Pitch is kept DW-aligned so every line base stays DW-aligned.
          w_pitch_nxt     = {line_pitch[LSIZE_WIDTH-1:2], 2'b00};
          w_num_lines_nxt = num_lines;
          w_eff_nxt       = w_eff;
          w_line_cnt_nxt  = '0;
          w_ovf_nxt       = 1'b0;
          w_state_nxt     = StWait;
        end
      end
      StWait: begin
        if (r_num_lines == '0) begin
          frame_done  = 1'b1;
          w_state_nxt = StIdle;
        end else if (r_pend != '0) begin
          w_start_line   = 1'b1;
          w_plane_nxt    = 2'd0;
          w_rem_nxt      = CW'(r_size);
          w_cur_addr_nxt = r_base[0];
          w_state_nxt    = StCalc;
        end
      end
      StCalc: begin
        if (r_rem == '0) begin
          w_state_nxt = StNext;
        end else begin
          w_chunk_nxt = w_chunk;
          w_state_nxt = StIssue;
        end
      end
      StIssue: begin
        if (w_accept) begin
          w_cur_addr_nxt = r_cur_addr + ADDR_WIDTH'(r_chunk);
          w_rem_nxt      = r_rem - r_chunk;
          if (r_rem != r_chunk) w_state_nxt = StCalc;
          else                  w_do_next   = 1'b1;
        end
      end
      StNext:  w_do_next = 1'b1;
      default: w_state_nxt = StIdle;
    endcase

    // Plane/line advance is folded into the final accept so frame_done lines up with it.
    if (w_do_next) begin
      if (w_last_plane) begin
        for (int unsigned p = 0; p < NUM_PLANES; p++) begin
          w_base_nxt[p] = r_base[p] + ADDR_WIDTH'(r_pitch);
        end
        w_line_cnt_nxt = r_line_cnt + LINES_WIDTH'(1);
        if (w_last_line) begin
          frame_done  = 1'b1;
          w_state_nxt = StIdle;
        end else begin
          w_state_nxt = StWait;
        end
      end else begin
        w_plane_nxt    = w_next_plane;
        w_rem_nxt      = CW'(r_size);
        w_cur_addr_nxt = w_next_base;
        w_state_nxt    = StCalc;
      end
    end

    if ((r_state == StIdle) && frame_start) begin
      w_pend_nxt = '0;
    end else if (w_inc && !w_start_line) begin
      if (r_pend == {PEND_WIDTH{1'b1}}) w_ovf_nxt  = 1'b1;
      else                              w_pend_nxt = r_pend + PEND_WIDTH'(1);
    end else if (!w_inc && w_start_line) begin
      w_pend_nxt = r_pend - PEND_WIDTH'(1);
    end
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      r_state     <= StIdle;
      r_base      <= '{default: '0};
      r_size      <= '0;
      r_pitch     <= '0;
      r_num_lines <= '0;
      r_line_cnt  <= '0;
      r_eff       <= '0;
      r_rem       <= '0;
      r_chunk     <= '0;
      r_cur_addr  <= '0;
      r_plane     <= '0;
      r_pend      <= '0;
      r_ovf       <= 1'b0;
      r_held      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_base      <= w_base_nxt;
      r_size      <= w_size_nxt;
      r_pitch     <= w_pitch_nxt;
      r_num_lines <= w_num_lines_nxt;
      r_line_cnt  <= w_line_cnt_nxt;
      r_eff       <= w_eff_nxt;
      r_rem       <= w_rem_nxt;
      r_chunk     <= w_chunk_nxt;
      r_cur_addr  <= w_cur_addr_nxt;
      r_plane     <= w_plane_nxt;
      r_pend      <= w_pend_nxt;
      r_ovf       <= w_ovf_nxt;
      // Keeps an offered request alive if bus mastering is revoked before acceptance.
      r_held      <= req_valid && !req_ready;
    end
  end

endmodule

// File: tb/tb_dma_multiplane_tlp_addr_gen.sv
// Scoreboard bench for dma_multiplane_tlp_addr_gen: directed frames push expected requests,
// a negedge monitor pops and compares every accepted request.
module tb_dma_multiplane_tlp_addr_gen;

  logic         axi_clk = 1'b0;
  logic         axi_reset_n;
  logic         cfg_bus_mast_en;
  logic [2:0]   cfg_setmaxpld;
  logic [191:0] fstart;
  logic [13:0]  line_size, line_pitch;
  logic [11:0]  num_lines;
  logic         frame_start, line_ready;
  logic         req_valid, req_ready;
  logic [63:0]  req_addr;
  logic [9:0]   req_len_dw;
  logic [1:0]   req_plane;
  logic         req_eol, req_eof, busy, frame_done, pend_ovf;

  typedef struct packed {
    logic [63:0] addr;
    logic [9:0]  len;
    logic [1:0]  plane;
    logic        eol;
    logic        eof;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          fd_cnt  = 0;
  int          fd_exp  = 0;
  logic [63:0] pb[3];

  always #5 axi_clk = ~axi_clk;

  dma_multiplane_tlp_addr_gen #(
    .NUM_PLANES(3), .ADDR_WIDTH(64), .LSIZE_WIDTH(14), .LINES_WIDTH(12),
    .MAX_PCIE_PAYLOAD_SIZE(4096), .PEND_WIDTH(3)
  ) dut (
    .axi_clk(axi_clk), .axi_reset_n(axi_reset_n), .cfg_bus_mast_en(cfg_bus_mast_en),
    .cfg_setmaxpld(cfg_setmaxpld), .fstart(fstart), .line_size(line_size),
    .line_pitch(line_pitch), .num_lines(num_lines), .frame_start(frame_start),
    .line_ready(line_ready), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len_dw(req_len_dw), .req_plane(req_plane),
    .req_eol(req_eol), .req_eof(req_eof), .busy(busy), .frame_done(frame_done),
    .pend_ovf(pend_ovf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge axi_clk) begin
    if (axi_reset_n && frame_done) fd_cnt++;
    if (axi_reset_n && req_valid && req_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_req: got addr 0x%0h expected no request", req_addr);
      end else begin
        e = sb.pop_front();
        check("req_addr", req_addr, e.addr);
        check("req_len/plane/eol/eof", {50'd0, req_len_dw, req_plane, req_eol, req_eof},
              {50'd0, e.len, e.plane, e.eol, e.eof});
      end
    end
  end

  task automatic push(input logic [63:0] a, input logic [9:0] l, input logic [1:0] p,
                      input logic eol, input logic eof);
    exp_t x;
    x.addr = a; x.len = l; x.plane = p; x.eol = eol; x.eof = eof;
    sb.push_back(x);
  endtask

  task automatic cfg(input logic [63:0] a0, input logic [63:0] a1, input logic [63:0] a2,
                     input logic [13:0] sz, input logic [13:0] pt, input logic [11:0] nl,
                     input logic [2:0] mpl);
    pb[0] = a0; pb[1] = a1; pb[2] = a2;
    fstart = {a2, a1, a0};
    line_size = sz; line_pitch = pt; num_lines = nl; cfg_setmaxpld = mpl;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    @(posedge axi_clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic pulse_lr();
    line_ready = 1'b1;
    @(posedge axi_clk); #1;
    line_ready = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int c = 0;
    while (!req_valid && c < budget) begin
      @(posedge axi_clk); #1;
      c++;
    end
    check("wait_valid", {63'd0, req_valid}, 64'd1);
  endtask

  task automatic wait_empty(input int budget);
    int c = 0;
    while (sb.size() != 0 && c < budget) begin
      @(posedge axi_clk); #1;
      c++;
    end
    check("drain", 64'(sb.size()), 64'd0);
    repeat (2) @(posedge axi_clk);
    #1;
    check("busy_after_frame", {63'd0, busy}, 64'd0);
    check("frame_done_count", 64'(fd_cnt), 64'(fd_exp));
  endtask

  initial begin
    axi_reset_n = 1'b0; cfg_bus_mast_en = 1'b1; req_ready = 1'b1;
    frame_start = 1'b0; line_ready = 1'b0;
    cfg(64'h0, 64'h0, 64'h0, 14'h0, 14'h0, 12'h0, 3'd0);
    repeat (3) @(posedge axi_clk);
    @(negedge axi_clk);
    check("rst_outputs", {req_valid, req_eol, req_eof, busy, frame_done, pend_ovf}, 64'd0);
    check("rst_fields", {req_addr[53:0], req_len_dw}, 64'd0);
    @(posedge axi_clk); #1;
    axi_reset_n = 1'b1;

    // Two lines x three planes, 128 B payload: 32 DW chunks across each 4 KB line.
    cfg(64'hA000_0000, 64'hB000_0000, 64'hC000_0000, 14'h1000, 14'h1000, 12'd2, 3'd0);
    for (int l = 0; l < 2; l++)
      for (int p = 0; p < 3; p++)
        for (int k = 0; k < 32; k++)
          push(pb[p] + 64'(l) * 64'h1000 + 64'(k) * 64'd128, 10'd32, 2'(p), k == 31,
               (l == 1) && (p == 2) && (k == 31));
    fd_exp++;
    pulse_fs();
    pulse_lr();
    pulse_lr();
    wait_empty(3000);

    // 4 KB crossing splits with 256 B payload.
    cfg(64'h0FC0, 64'h2000, 64'h3F80, 14'h100, 14'h100, 12'd1, 3'd1);
    push(64'h0FC0, 10'd16, 2'd0, 1'b0, 1'b0);
    push(64'h1000, 10'd48, 2'd0, 1'b1, 1'b0);
    push(64'h2000, 10'd64, 2'd1, 1'b1, 1'b0);
    push(64'h3F80, 10'd32, 2'd2, 1'b0, 1'b0);
    push(64'h4000, 10'd32, 2'd2, 1'b1, 1'b1);
    fd_exp++;
    pulse_fs();
    pulse_lr();
    wait_empty(200);

    // Max payload code above 5 clamps to 4096 B; a 4096 B chunk encodes length 0.
    cfg(64'h5000, 64'h6000, 64'h7000, 14'h1000, 14'h1000, 12'd1, 3'd7);
    push(64'h5000, 10'd0, 2'd0, 1'b1, 1'b0);
    push(64'h6000, 10'd0, 2'd1, 1'b1, 1'b0);
    push(64'h7000, 10'd0, 2'd2, 1'b1, 1'b1);
    fd_exp++;
    pulse_fs();
    pulse_lr();
    wait_empty(200);

    // Three planes, one 128 B line each, issued in plane order.
    cfg(64'h1000_0000, 64'h2000_0000, 64'h3000_0000, 14'h80, 14'h80, 12'd1, 3'd0);
    push(64'h1000_0000, 10'd32, 2'd0, 1'b1, 1'b0);
    push(64'h2000_0000, 10'd32, 2'd1, 1'b1, 1'b0);
    push(64'h3000_0000, 10'd32, 2'd2, 1'b1, 1'b1);
    fd_exp++;
    pulse_fs();
    pulse_lr();
    wait_empty(200);

    // Backpressure, pending saturation, and bus-master drop.
    push(64'h1000_0000, 10'd32, 2'd0, 1'b1, 1'b0);
    push(64'h2000_0000, 10'd32, 2'd1, 1'b1, 1'b0);
    push(64'h3000_0000, 10'd32, 2'd2, 1'b1, 1'b1);
    fd_exp++;
    req_ready = 1'b0;
    pulse_fs();
    pulse_lr();
    wait_valid(50);
    for (int i = 0; i < 20; i++) begin
      line_ready = (i < 8);
      @(negedge axi_clk);
      check("stall_valid", {63'd0, req_valid}, 64'd1);
      check("stall_addr", req_addr, 64'h1000_0000);
      @(posedge axi_clk); #1;
    end
    line_ready = 1'b0;
    check("pend_ovf_set", {63'd0, pend_ovf}, 64'd1);
    cfg_bus_mast_en = 1'b0;
    @(negedge axi_clk);
    check("held_after_en_drop", {63'd0, req_valid}, 64'd1);
    @(posedge axi_clk); #1;
    req_ready = 1'b1;
    @(posedge axi_clk); #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge axi_clk);
      check("no_req_en_low", {63'd0, req_valid}, 64'd0);
    end
    @(posedge axi_clk); #1;
    cfg_bus_mast_en = 1'b1;
    wait_empty(200);

    // Zero-line frame: frame_done one cycle after frame_start; pend_ovf cleared.
    cfg(64'h1000_0000, 64'h2000_0000, 64'h3000_0000, 14'h80, 14'h80, 12'd0, 3'd0);
    fd_exp++;
    frame_start = 1'b1;
    @(posedge axi_clk); #1;
    frame_start = 1'b0;
    @(negedge axi_clk);
    check("zero_lines_done", {62'd0, frame_done, busy}, 64'd3);
    check("pend_ovf_cleared", {63'd0, pend_ovf}, 64'd0);
    @(negedge axi_clk);
    check("zero_lines_idle", {62'd0, frame_done, busy}, 64'd0);
    wait_empty(20);

    // Asynchronous reset mid-line aborts the frame without frame_done.
    cfg(64'h1000_0000, 64'h2000_0000, 64'h3000_0000, 14'h80, 14'h80, 12'd1, 3'd0);
    req_ready = 1'b0;
    pulse_fs();
    pulse_lr();
    wait_valid(50);
    axi_reset_n = 1'b0;
    #1;
    check("rst_mid_ctrl", {61'd0, req_valid, busy, req_eol}, 64'd0);
    check("rst_mid_addr", req_addr, 64'd0);
    repeat (2) @(posedge axi_clk);
    #1;
    axi_reset_n = 1'b1;
    req_ready = 1'b1;
    repeat (5) @(posedge axi_clk);
    #1;
    check("rst_no_done", 64'(fd_cnt), 64'(fd_exp));
    check("rst_idle", {63'd0, busy}, 64'd0);

    // Recovery after reset.
    push(64'h1000_0000, 10'd32, 2'd0, 1'b1, 1'b0);
    push(64'h2000_0000, 10'd32, 2'd1, 1'b1, 1'b0);
    push(64'h3000_0000, 10'd32, 2'd2, 1'b1, 1'b1);
    fd_exp++;
    pulse_fs();
    pulse_lr();
    wait_empty(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_multiplane_tlp_addr_gen.md
Name: dma_multiplane_tlp_addr_gen

Overview:
Parametrised successor to the single-plane DMA frame-start/line-size/line-pitch address path of XGS_athena. Generates PCIe memory-write requests (address and DW length) for up to NUM_PLANES image planes (e.g. Y/G/R), one line at a time. Each line is split into TLP-sized chunks bounded by the negotiated max payload and by 4 KB address boundaries. Sits between the line-buffer controller and the TLP formatter that feeds pcie_tx_axi.

Parameters:
NUM_PLANES, 3, number of planes whose start addresses are used (1..4)
ADDR_WIDTH, 64, host address width
LSIZE_WIDTH, 14, width of line_size and line_pitch in bytes
LINES_WIDTH, 12, width of the lines-per-frame count
MAX_PCIE_PAYLOAD_SIZE, 128, hard cap on TLP payload in bytes (power of 2, 128..4096)
PEND_WIDTH, 3, width of the pending-line counter

Ports:
axi_clk  in  1  sole clock
axi_reset_n  in  1  asynchronous active-low reset
cfg_bus_mast_en  in  1  bus-master enable; no new request is issued while low
cfg_setmaxpld  in  3  PCIe max-payload encoding (0=128 B .. 5=4096 B)
fstart  in  NUM_PLANES*ADDR_WIDTH  per-plane frame start address, plane p in bits [p*ADDR_WIDTH +: ADDR_WIDTH]
line_size  in  LSIZE_WIDTH  bytes per line per plane
line_pitch  in  LSIZE_WIDTH  byte stride between lines
num_lines  in  LINES_WIDTH  lines per frame
frame_start  in  1  single-cycle pulse; starts a frame
line_ready  in  1  single-cycle pulse; one line (all planes) is available
req_valid  out  1  request valid
req_ready  in  1  request accepted by the TLP formatter
req_addr  out  ADDR_WIDTH  DW-aligned write address
req_len_dw  out  10  payload length in DW (1..1024)
req_plane  out  2  plane index
req_eol  out  1  last chunk of this plane's line
req_eof  out  1  last chunk of the frame
busy  out  1  frame in progress
frame_done  out  1  single-cycle pulse when the last request of the frame is accepted
pend_ovf  out  1  sticky flag: line_ready arrived with the pending counter saturated; cleared by frame_start

Behaviour:
- Reset values: all outputs 0; state IDLE; pending counter 0.
- Register capture: on frame_start in IDLE, fstart, line_size, line_pitch, num_lines and the effective payload are shadowed. Address bits [1:0] and line_size[1:0] are forced to 0. Mid-frame input changes have no effect.
- Effective payload: eff = min(128 << min(cfg_setmaxpld, 5), MAX_PCIE_PAYLOAD_SIZE).
- A frame_start while busy is ignored; no flag is raised.
- Pending counter: incremented by line_ready and decremented when a line starts. If both occur in the same cycle, the count is unchanged. The counter saturates at 2^PEND_WIDTH-1; a line_ready at saturation sets pend_ovf. line_ready in IDLE is ignored.
- State machine:
  - IDLE: on frame_start go to WAIT; busy goes to 1 the next cycle. If num_lines==0, pulse frame_done one cycle after frame_start and return to IDLE.
  - WAIT: when pending>0, set plane=0 and rem=line_size, then go to CALC.
  - CALC (1 cycle): chunk = min(rem, eff, 4096 - cur_addr[11:0]). If rem==0 (line_size 0), skip to NEXT. Otherwise go to ISSUE.
  - ISSUE: req_valid=1 only when cfg_bus_mast_en=1. Once asserted, req_valid and all req_* fields stay stable until req_ready. On accept: cur_addr += chunk; rem -= chunk; go to CALC if rem>0, else NEXT.
  - NEXT: advance plane. After the last plane: line_base[p] += line_pitch for every plane and line_cnt++. If line_cnt==num_lines, go to IDLE and pulse frame_done in the same cycle as the final accept. Otherwise go to WAIT.
- Request fields: req_len_dw = chunk>>2 (4096 B encodes as 0 per PCIe). req_eol=1 when rem==chunk. req_eof=1 when req_eol and this is the last plane of the last line.
- Address arithmetic is modulo 2^ADDR_WIDTH. line_pitch < line_size is legal (lines overlap); no check is made.
- cfg_bus_mast_en falling while req_valid=1: the current request is held until accepted; no further requests are issued.
- Asynchronous reset mid-frame aborts immediately: no frame_done, pending count cleared.

Test Plan:
- NUM_PLANES=1, fstart=0xA0000000, line_size=0x1000, pitch=0x1000, num_lines=2, cfg_setmaxpld=0 -> 64 requests of 32 DW each. Line 2 starts at 0xA0001000. req_eof only on the 64th request. frame_done pulses once.
- Plane 0 fstart=0x0FC0, line_size=0x100, eff=256 -> two requests: 0x0FC0/16 DW, then 0x1000/48 DW, with no 4 KB crossing.
- NUM_PLANES=3, planes at 0x1000_0000, 0x2000_0000 and 0x3000_0000, line_size=0x80, num_lines=1 -> exactly three 32-DW requests issued in plane order 0,1,2.
- req_ready held low for 20 cycles -> req_valid and req_addr remain stable. Dropping cfg_bus_mast_en mid-line -> no new req_valid until re-enabled.
- 8 line_ready pulses with PEND_WIDTH=3 while backpressured -> count saturates at 7 and pend_ovf=1. The next frame_start clears pend_ovf.
- num_lines=0 -> frame_done one cycle after frame_start with no requests. axi_reset_n low mid-line -> all outputs 0, busy=0.
